uart_tx_fifo: RTL

//   Synthesizable 8N1 UART transmitter with a small input FIFO. Drives the SoC-side
//   ser_rx line from on-chip or bench-side producers. Bit timing matches the

---
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [7:0]                      in_data,
  output logic                            in_ready,
  output logic                            ser_tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
  localparam int TW = $clog2(CLK_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          tail_q, tail_d;
  logic          push, pop, load, tick;
  logic [7:0]    rd_data;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign in_ready   = (level_q != FULL);
  assign push       = in_valid && in_ready;
  assign rd_data    = mem_q[rd_ptr_q];
  assign tick       = (timer_q == TMAX);
  assign ser_tx     = tx_q;
  assign fifo_level = level_q;
  // tail_q covers the final stop cycle still on the line after state goes IDLE
  assign busy = (state_q != IDLE) || (level_q != '0) || tail_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = tick ? '0 : timer_q + TW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    load    = 1'b0;
    pop     = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        load    = (level_q != '0);
      end
      START: begin
        tx_d = 1'b0;
        if (tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = par_q;
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          load    = (level_q != '0);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      shift_d = rd_data;
      timer_d = '0;
      state_d = START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^rd_data;
`endif
    end
    tail_d = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      tail_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      tail_q   <= tail_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule
